// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_D_WAIT = 2'd1;
  localparam logic [1:0] ST_I_WAIT = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StDWait = ST_D_WAIT,
    StIWait = ST_I_WAIT
  } arb_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait-cycle counter; expired flags the MAX_WAIT-th cycle spent waiting.
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MAX_WAIT);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count starts at 0 in the first waiting cycle, so MAX_WAIT-1 marks the last allowed one.
  assign expired = enable && (cnt_q >= CntLast);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage, freezing the
// pipeline until every pending access has been served. Data accesses win over fetches.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              freeze,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);

  arb_state_e        state_q, state_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              data_served_q, data_served_d;
  logic              inst_served_q, inst_served_d;
  logic              err_q, err_d;
  logic              flush_seen_q, flush_seen_d;
  logic              data_pend, inst_pend, expired, waiting;

  assign data_pend = (mem_r_en || mem_w_en) && !data_served_q;
  assign inst_pend = if_req && !inst_served_q && !if_flush;
  assign freeze    = data_pend || inst_pend;
  assign waiting   = (state_q != StIdle);

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!waiting),
    .enable (waiting),
    .expired(expired)
  );

  always_comb begin
    state_d      = state_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    err_d        = err_q;
    flush_seen_d = flush_seen_q;
    // Pipeline advances on any unfrozen edge; a flush also drops a held instruction.
    data_served_d = freeze ? data_served_q : 1'b0;
    inst_served_d = (freeze && !if_flush) ? inst_served_q : 1'b0;

    unique case (state_q)
      StIdle: begin
        flush_seen_d = 1'b0;
        if (data_pend) begin
          m_req_d   = 1'b1;
          m_we_d    = mem_w_en;
          m_addr_d  = mem_addr;
          m_wdata_d = mem_wdata;
          state_d   = StDWait;
        end else if (inst_pend) begin
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = if_addr;
          state_d  = StIWait;
        end
      end
      StDWait: begin
        if (m_ack || expired) begin
          m_req_d       = 1'b0;
          data_served_d = 1'b1;
          state_d       = StIdle;
          if (!m_we_q) mem_rdata_d = m_ack ? m_rdata : '0;
          if (!m_ack) err_d = 1'b1;
        end
      end
      StIWait: begin
        if (if_flush) flush_seen_d = 1'b1;
        if (m_ack || expired) begin
          m_req_d = 1'b0;
          state_d = StIdle;
          if (!m_ack) err_d = 1'b1;
          // A fetch overtaken by a branch completes on the bus but its data is dropped.
          if (!(flush_seen_q || if_flush)) begin
            if_rdata_d    = m_ack ? m_rdata : '0;
            inst_served_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      m_req_q       <= 1'b0;
      m_we_q        <= 1'b0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      if_rdata_q    <= '0;
      mem_rdata_q   <= '0;
      data_served_q <= 1'b0;
      inst_served_q <= 1'b0;
      err_q         <= 1'b0;
      flush_seen_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_req_q       <= m_req_d;
      m_we_q        <= m_we_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      if_rdata_q    <= if_rdata_d;
      mem_rdata_q   <= mem_rdata_d;
      data_served_q <= data_served_d;
      inst_served_q <= inst_served_d;
      err_q         <= err_d;
      flush_seen_q  <= flush_seen_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign err       = err_q;

endmodule
